// File: rtl/sw_debounce.sv
// sw_debounce: switch synchroniser + bounce filter for the DE2 switch bank.
// Each bit is synchronised, then must differ from the accepted level for
// STABLE_TICKS consecutive prescaler ticks before the new level is taken.
// Optional feature macro: SW_EVENT_LATCH_EN builds the sticky event register.

// Per-bit stability qualifier: counts ticks while the synchronised input
// differs from the accepted level, restarts on any bounce back.
module sw_debounce_bit #(
   parameter int STABLE_TICKS = 10
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sync,
   input  logic i_tick,
   output logic o_db,
   output logic o_rise,
   output logic o_fall
);
   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Qualification: equal input clears progress; the last tick flips the level.
   always_comb begin
      cnt_d  = cnt_q;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (i_sync == db_q) begin
         cnt_d = '0;
      end else if (i_tick) begin
         if (cnt_q == CNT_LAST) begin
            db_d   = i_sync;
            cnt_d  = '0;
            rise_d = i_sync;
            fall_d = ~i_sync;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Pulses are registered alongside the level so they line up with it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign o_db   = db_q;
   assign o_rise = rise_q;
   assign o_fall = fall_q;
endmodule

module sw_debounce #(
   parameter int WIDTH        = 18,
   parameter int TICK_CYCLES  = 50000,
   parameter int STABLE_TICKS = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_sw_raw,
   input  logic             i_evt_clr,
   input  logic [WIDTH-1:0] i_evt_clr_mask,
   output logic [WIDTH-1:0] o_sw_db,
   output logic [WIDTH-1:0] o_sw_rise,
   output logic [WIDTH-1:0] o_sw_fall,
   output logic [WIDTH-1:0] o_sw_event
);
   // A one-cycle prescaler still needs a 1-bit register to stay well formed.
   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [PW-1:0]    pre_q, pre_d;
   logic             tick;

   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : pre_q + 1'b1;

   // Two-flop synchroniser and shared sample prescaler.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         pre_q   <= '0;
      end else begin
         sync1_q <= i_sw_raw;
         sync2_q <= sync1_q;
         pre_q   <= pre_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_sync (sync2_q[i]),
         .i_tick (tick),
         .o_db   (o_sw_db[i]),
         .o_rise (o_sw_rise[i]),
         .o_fall (o_sw_fall[i])
      );
   end

`ifdef SW_EVENT_LATCH_EN
   logic [WIDTH-1:0] evt_q, evt_d;

   // Sticky change flags; a pulse in the same cycle as a clear keeps its bit.
   always_comb begin
      evt_d = (evt_q & ~({WIDTH{i_evt_clr}} & i_evt_clr_mask)) | o_sw_rise | o_sw_fall;
   end

   // Event register.
   always_ff @(posedge i_clk) begin
      if (i_rst) evt_q <= '0;
      else       evt_q <= evt_d;
   end

   assign o_sw_event = evt_q;
`else
   logic unused_evt_in;
   assign unused_evt_in = ^{i_evt_clr, i_evt_clr_mask};
   assign o_sw_event    = '0;
`endif
endmodule
